// File: rtl/timer_bus_arb_pkg.sv
// Shared types and constants for the timer local-bus arbiter.
// Holds the FSM encoding, bus widths, the lock-timeout default and a payload packer.
package timer_bus_arb_pkg;

    localparam int XLEN         = 32;
    localparam int AW           = 16;
    localparam int WEW          = 3;
    localparam int LOCK_TMO_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_CAPT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic [AW-1:0]   addr;
        logic [WEW-1:0]  we;
        logic [XLEN-1:0] wdata;
        logic            lock;
    } arb_payload_t;

    function automatic arb_payload_t pack_payload(
        input logic [AW-1:0]   addr,
        input logic [WEW-1:0]  we,
        input logic [XLEN-1:0] wdata,
        input logic            lock
    );
        arb_payload_t p;
        p.addr  = addr;
        p.we    = we;
        p.wdata = wdata;
        p.lock  = lock;
        return p;
    endfunction

endpackage

// File: rtl/timer_bus_arb_if.sv
// Two bus-master request ports plus the timer's single sel/addr/we/wdata/rdata port.
// slave = arbiter view, master = fabric-and-timer view.
interface timer_bus_arb_if;
    import timer_bus_arb_pkg::*;

    logic            m0_req;
    logic            m0_lock;
    logic [AW-1:0]   m0_addr;
    logic [WEW-1:0]  m0_we;
    logic [XLEN-1:0] m0_wdata;
    logic            m0_ack;
    logic [XLEN-1:0] m0_rdata;

    logic            m1_req;
    logic            m1_lock;
    logic [AW-1:0]   m1_addr;
    logic [WEW-1:0]  m1_we;
    logic [XLEN-1:0] m1_wdata;
    logic            m1_ack;
    logic [XLEN-1:0] m1_rdata;

    logic            sel;
    logic [AW-1:0]   addr;
    logic [WEW-1:0]  we;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] rdata;

    modport slave (
        input  m0_req, m0_lock, m0_addr, m0_we, m0_wdata,
        input  m1_req, m1_lock, m1_addr, m1_we, m1_wdata,
        input  rdata,
        output m0_ack, m0_rdata, m1_ack, m1_rdata,
        output sel, addr, we, wdata
    );

    modport master (
        output m0_req, m0_lock, m0_addr, m0_we, m0_wdata,
        output m1_req, m1_lock, m1_addr, m1_we, m1_wdata,
        output rdata,
        input  m0_ack, m0_rdata, m1_ack, m1_rdata,
        input  sel, addr, we, wdata
    );

endinterface

// File: rtl/timer_bus_arb_rr2.sv
// Two-input round-robin pick with lock mask.
// Latency: combinational. Backpressure: none; a held lock masks the non-owner.
// The caller decides when the grant is consumed.
module timer_bus_arb_rr2
    import timer_bus_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last,
    input  logic       i_lock_vld,
    input  logic       i_lock_owner,
    output logic       o_grant_id,
    output logic       o_grant_vld
);

    always_comb begin
        o_grant_id  = 1'b0;
        o_grant_vld = 1'b0;
        if (i_lock_vld) begin
            o_grant_id  = i_lock_owner;
            o_grant_vld = i_req[i_lock_owner];
        end else begin
            o_grant_vld = |i_req;
            case (i_req)
                2'b01:   o_grant_id = 1'b0;
                2'b10:   o_grant_id = 1'b1;
                // tie goes to whoever was not served last
                2'b11:   o_grant_id = ~i_last;
                default: o_grant_id = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/timer_bus_arb.sv
// Serialises two masters onto the timer local bus, round-robin with an optional ownership lock.
// Latency: req in IDLE at T -> sel T+1, rdata capture T+2, ack T+3, IDLE again T+4.
// Backpressure: masters hold req+payload until ack; losers and locked-out masters simply wait.
module timer_bus_arb
    import timer_bus_arb_pkg::*;
#(
    parameter int LOCK_TMO = LOCK_TMO_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    timer_bus_arb_if.slave  bus
);

    localparam int CW = $clog2(LOCK_TMO + 1);

    arb_state_t      r_state;
    arb_state_t      w_state_nxt;
    arb_payload_t    r_pl;
    arb_payload_t    w_pl0;
    arb_payload_t    w_pl1;
    logic            r_owner;
    logic            r_last;
    logic            r_lock_vld;
    logic            r_lock_owner;
    logic [CW-1:0]   r_lock_cnt;
    logic [XLEN-1:0] r_m0_rdata;
    logic [XLEN-1:0] r_m1_rdata;

    logic [1:0]      w_req;
    logic            w_grant_id;
    logic            w_grant_vld;
    logic            w_grant;
    logic            w_sel;
    logic            w_done;
    logic            w_capt;
    logic            w_own_req;
    logic            w_lock_wait;

    assign w_req = {bus.m1_req, bus.m0_req};
    assign w_pl0 = pack_payload(bus.m0_addr, bus.m0_we, bus.m0_wdata, bus.m0_lock);
    assign w_pl1 = pack_payload(bus.m1_addr, bus.m1_we, bus.m1_wdata, bus.m1_lock);

    timer_bus_arb_rr2 u_rr2 (
        .i_req        (w_req),
        .i_last       (r_last),
        .i_lock_vld   (r_lock_vld),
        .i_lock_owner (r_lock_owner),
        .o_grant_id   (w_grant_id),
        .o_grant_vld  (w_grant_vld)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_sel       = 1'b0;
        w_capt      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_vld) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_sel       = 1'b1;
                w_state_nxt = ST_CAPT;
            end
            ST_CAPT: begin
                w_capt      = 1'b1;
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Payload is frozen at grant; later changes on the master side are ignored.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pl    <= '0;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
        end else if (w_grant) begin
            r_pl    <= w_grant_id ? w_pl1 : w_pl0;
            r_owner <= w_grant_id;
            r_last  <= w_grant_id;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_m0_rdata <= '0;
            r_m1_rdata <= '0;
        end else if (w_capt) begin
            if (r_owner) begin
                r_m1_rdata <= bus.rdata;
            end else begin
                r_m0_rdata <= bus.rdata;
            end
        end
    end

    assign w_own_req   = r_lock_owner ? bus.m1_req : bus.m0_req;
    assign w_lock_wait = (r_state == ST_IDLE) && r_lock_vld && !w_own_req;

    // An owner that goes quiet for LOCK_TMO idle cycles forfeits the lock.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lock_vld   <= 1'b0;
            r_lock_owner <= 1'b0;
            r_lock_cnt   <= '0;
        end else begin
            if (w_done) begin
                if (r_pl.lock) begin
                    r_lock_vld   <= 1'b1;
                    r_lock_owner <= r_owner;
                end else if (r_lock_owner == r_owner) begin
                    r_lock_vld   <= 1'b0;
                end
            end
            if (w_grant) begin
                r_lock_cnt <= '0;
            end else if (w_lock_wait) begin
                if (r_lock_cnt == CW'(LOCK_TMO - 1)) begin
                    r_lock_cnt <= '0;
                    r_lock_vld <= 1'b0;
                end else begin
                    r_lock_cnt <= r_lock_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.sel      = w_sel;
    assign bus.addr     = w_sel ? r_pl.addr  : '0;
    assign bus.we       = w_sel ? r_pl.we    : '0;
    assign bus.wdata    = w_sel ? r_pl.wdata : '0;
    assign bus.m0_ack   = w_done & ~r_owner;
    assign bus.m1_ack   = w_done &  r_owner;
    assign bus.m0_rdata = r_m0_rdata;
    assign bus.m1_rdata = r_m1_rdata;

endmodule

// File: tb/tb_timer_bus_arb.sv
// Random and directed stimulus for timer_bus_arb, checked every cycle against a transaction-schedule model.
module tb_timer_bus_arb;
    import timer_bus_arb_pkg::*;

    localparam int TMO = 16;

    typedef struct {
        logic [15:0] addr;
        logic [2:0]  we;
        logic [31:0] wdata;
        logic        lock;
    } mreq_t;

    logic clk = 1'b0;
    logic rst_n;

    timer_bus_arb_if bus();

    timer_bus_arb #(.LOCK_TMO(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int    n_vec = 0;
    int    n_err = 0;
    int    cyc   = 0;
    mreq_t q0[$];
    mreq_t q1[$];
    bit    rd_rand = 1'b0;
    logic [31:0] rd_fix = 32'h0;

    // model: a grant at cycle g implies sel at g+1, capture at g+2, ack at g+3, free at g+4
    bit          mdl_ok = 1'b0;
    int          g_cyc = -100;
    int          free_at = 0;
    bit          g_own = 1'b0;
    mreq_t       g_pl;
    bit          last_w = 1'b1;
    bit          lk_held = 1'b0;
    bit          lk_own = 1'b0;
    int          lk_idle = 0;
    logic [31:0] m_rd0 = 32'h0;
    logic [31:0] m_rd1 = 32'h0;
    bit          ack_seen0 = 1'b0;
    bit          ack_seen1 = 1'b0;

    function automatic mreq_t mk(input logic [15:0] a, input logic [2:0] w,
                                 input logic [31:0] d, input logic l);
        mreq_t r;
        r.addr  = a;
        r.we    = w;
        r.wdata = d;
        r.lock  = l;
        return r;
    endfunction

    function automatic mreq_t rand_req();
        return mk(16'($urandom), 3'($urandom_range(7)), $urandom, ($urandom_range(3) == 0));
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s cycle %0d: got %h want %h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_cycle();
        bit e_sel, e_a0, e_a1;
        int w;
        e_sel = (cyc == g_cyc + 1);
        e_a0  = (cyc == g_cyc + 3) && !g_own;
        e_a1  = (cyc == g_cyc + 3) && g_own;
        if (mdl_ok) begin
            chk("sel",      32'(bus.sel),    32'(e_sel));
            chk("addr",     32'(bus.addr),   e_sel ? 32'(g_pl.addr) : 32'd0);
            chk("we",       32'(bus.we),     e_sel ? 32'(g_pl.we)   : 32'd0);
            chk("wdata",    bus.wdata,       e_sel ? g_pl.wdata     : 32'd0);
            chk("m0_ack",   32'(bus.m0_ack), 32'(e_a0));
            chk("m1_ack",   32'(bus.m1_ack), 32'(e_a1));
            chk("m0_rdata", bus.m0_rdata,    m_rd0);
            chk("m1_rdata", bus.m1_rdata,    m_rd1);
        end
        ack_seen0 = mdl_ok && e_a0;
        ack_seen1 = mdl_ok && e_a1;
        if (rst_n == 1'b0) begin
            g_cyc   = -100;
            free_at = 0;
            last_w  = 1'b1;
            lk_held = 1'b0;
            lk_idle = 0;
            m_rd0   = 32'h0;
            m_rd1   = 32'h0;
            mdl_ok  = 1'b1;
        end else if (mdl_ok) begin
            if (cyc == g_cyc + 2) begin
                if (g_own) m_rd1 = bus.rdata;
                else       m_rd0 = bus.rdata;
            end
            if (cyc == g_cyc + 3) begin
                if (g_pl.lock) begin
                    lk_held = 1'b1;
                    lk_own  = g_own;
                end else if (lk_held && lk_own == g_own) begin
                    lk_held = 1'b0;
                end
            end
            if (cyc >= free_at) begin
                w = -1;
                if (lk_held) begin
                    if (lk_own ? bus.m1_req : bus.m0_req) w = lk_own ? 1 : 0;
                    else begin
                        lk_idle++;
                        if (lk_idle == TMO) begin
                            lk_held = 1'b0;
                            lk_idle = 0;
                        end
                    end
                end else if (bus.m0_req && bus.m1_req) w = last_w ? 0 : 1;
                else if (bus.m0_req) w = 0;
                else if (bus.m1_req) w = 1;
                if (w >= 0) begin
                    lk_idle = 0;
                    last_w  = (w == 1);
                    g_own   = (w == 1);
                    g_cyc   = cyc;
                    free_at = cyc + 4;
                    if (w == 1) g_pl = mk(bus.m1_addr, bus.m1_we, bus.m1_wdata, bus.m1_lock);
                    else        g_pl = mk(bus.m0_addr, bus.m0_we, bus.m0_wdata, bus.m0_lock);
                end
            end
        end
    endtask

    // Masters present their queue head; idle masters put junk on the payload lines.
    task automatic apply();
        if (q0.size() > 0) begin
            bus.m0_req = 1'b1;        bus.m0_addr = q0[0].addr;  bus.m0_we = q0[0].we;
            bus.m0_wdata = q0[0].wdata; bus.m0_lock = q0[0].lock;
        end else begin
            bus.m0_req = 1'b0;        bus.m0_addr = 16'($urandom); bus.m0_we = 3'($urandom_range(7));
            bus.m0_wdata = $urandom;  bus.m0_lock = 1'($urandom_range(1));
        end
        if (q1.size() > 0) begin
            bus.m1_req = 1'b1;        bus.m1_addr = q1[0].addr;  bus.m1_we = q1[0].we;
            bus.m1_wdata = q1[0].wdata; bus.m1_lock = q1[0].lock;
        end else begin
            bus.m1_req = 1'b0;        bus.m1_addr = 16'($urandom); bus.m1_we = 3'($urandom_range(7));
            bus.m1_wdata = $urandom;  bus.m1_lock = 1'($urandom_range(1));
        end
        bus.rdata = rd_rand ? $urandom : rd_fix;
    endtask

    task automatic sample();
        @(negedge clk);
        model_cycle();
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        cyc++;
        if (ack_seen0) q0.delete(0);
        if (ack_seen1) q1.delete(0);
        apply();
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    initial begin
        rst_n = 1'b0;
        apply();
        step();
        step();
        rst_n = 1'b1;

        // single read by m0
        rd_fix = 32'h1234_5678;
        q0.push_back(mk(16'h0000, 3'd0, 32'h0, 1'b0));
        apply();
        for (int i = 0; i < 6; i++) begin
            sample();
            chk("rd_sel",  32'(bus.sel),    32'(i == 1));
            chk("rd_ack0", 32'(bus.m0_ack), 32'(i == 3));
            chk("rd_ack1", 32'(bus.m1_ack), 32'd0);
            if (i >= 3) chk("rd_rdata0", bus.m0_rdata, 32'h1234_5678);
            advance();
        end

        // tie from reset: alternate m0, m1, m0, m1
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            q0.push_back(mk(16'h0010, 3'd0, 32'h0, 1'b0));
            q1.push_back(mk(16'h0020, 3'd0, 32'h0, 1'b0));
        end
        apply();
        for (int i = 0; i < 16; i++) begin
            sample();
            chk("tie_sel", 32'(bus.sel), 32'(i % 4 == 1));
            if (i % 4 == 1) chk("tie_addr", 32'(bus.addr), ((i / 4) % 2 == 1) ? 32'h20 : 32'h10);
            chk("tie_ack0", 32'(bus.m0_ack), 32'((i % 4 == 3) && ((i / 4) % 2 == 0)));
            chk("tie_ack1", 32'(bus.m1_ack), 32'((i % 4 == 3) && ((i / 4) % 2 == 1)));
            advance();
        end

        // locked 64-bit write by m1 while m0 keeps asking
        q1.push_back(mk(16'h4000, 3'd4, 32'hAAAA_0001, 1'b1));
        q1.push_back(mk(16'h4004, 3'd4, 32'hAAAA_0002, 1'b0));
        apply();
        for (int i = 0; i < 13; i++) begin
            if (i == 1) begin
                q0.push_back(mk(16'h0100, 3'd2, 32'h5555_0000, 1'b0));
                apply();
            end
            sample();
            chk("lk_sel", 32'(bus.sel), 32'(i == 1 || i == 5 || i == 9));
            if (i == 1) chk("lk_addr1", 32'(bus.addr), 32'h4000);
            if (i == 5) chk("lk_addr2", 32'(bus.addr), 32'h4004);
            if (i == 9) chk("lk_addr3", 32'(bus.addr), 32'h0100);
            if (i == 9) chk("lk_we3", 32'(bus.we), 32'd2);
            chk("lk_ack0", 32'(bus.m0_ack), 32'(i == 11));
            chk("lk_ack1", 32'(bus.m1_ack), 32'(i == 3 || i == 7));
            advance();
        end

        // abandoned lock by m0 expires after TMO idle cycles
        q0.push_back(mk(16'h0008, 3'd1, 32'h1, 1'b1));
        apply();
        for (int i = 0; i < 25; i++) begin
            if (i == 1) begin
                q1.push_back(mk(16'h000C, 3'd0, 32'h0, 1'b0));
                apply();
            end
            sample();
            chk("tmo_sel", 32'(bus.sel), 32'(i == 1 || i == 21));
            if (i == 21) chk("tmo_addr", 32'(bus.addr), 32'h000C);
            chk("tmo_ack0", 32'(bus.m0_ack), 32'(i == 3));
            chk("tmo_ack1", 32'(bus.m1_ack), 32'(i == 23));
            advance();
        end

        // reset in the capture cycle of an m1 read
        rd_fix = 32'hCAFE_F00D;
        q1.push_back(mk(16'h0020, 3'd0, 32'h0, 1'b0));
        apply();
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        q0.push_back(mk(16'h0030, 3'd0, 32'h0, 1'b0));
        apply();
        sample();
        chk("rst_sel",   32'(bus.sel),    32'd0);
        chk("rst_addr",  32'(bus.addr),   32'd0);
        chk("rst_we",    32'(bus.we),     32'd0);
        chk("rst_wdata", bus.wdata,       32'd0);
        chk("rst_ack0",  32'(bus.m0_ack), 32'd0);
        chk("rst_ack1",  32'(bus.m1_ack), 32'd0);
        chk("rst_rd0",   bus.m0_rdata,    32'd0);
        chk("rst_rd1",   bus.m1_rdata,    32'd0);
        advance();
        sample();
        chk("rst_first_sel",  32'(bus.sel),    32'd1);
        chk("rst_first_addr", 32'(bus.addr),   32'h0030);
        chk("rst_no_ack1",    32'(bus.m1_ack), 32'd0);
        advance();
        for (int i = 0; i < 40 && (q0.size() + q1.size()) > 0; i++) step();

        // randomized traffic with locks and occasional resets
        rd_rand = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (q0.size() < 2 && $urandom_range(7) == 0) q0.push_back(rand_req());
            if (q1.size() < 2 && $urandom_range(7) == 0) q1.push_back(rand_req());
            rst_n = ($urandom_range(399) != 0);
            apply();
            step();
        end
        rst_n = 1'b1;
        for (int c = 0; c < 120; c++) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/timer_bus_arb.md
# timer_bus_arb

Two-master arbiter for the timer register block's single local bus. Master 0 is the core load/store path; master 1 is the debug/system bus bridge. The block serialises their accesses onto the timer's sel/addr/we/wdata/rdata port with round-robin fairness. It also provides a lock so one master can perform multi-word accesses (64-bit mtime/mtimecmp halves) atomically. It sits between the bus fabric and the timer top, one instance per timer.

## Interface
- XLEN, 32, data width (from core_general.vh)
- LOCK_TMO, 16, idle cycles after which an abandoned lock is released
- clk  in  1  global clock
- rst_n  in  1  synchronous active-low reset
- m0_req / m1_req  in  1  request; held with payload until ack
- m0_lock / m1_lock  in  1  keep ownership after this transaction
- m0_addr / m1_addr  in  16  register address
- m0_we / m1_we  in  3  write enable code; 0 = read
- m0_wdata / m1_wdata  in  XLEN  write data
- m0_ack / m1_ack  out  1  one-cycle completion pulse
- m0_rdata / m1_rdata  out  XLEN  read data, valid with ack and held until the next ack to that master
- sel  out  1  timer select
- addr  out  16  timer address
- we  out  3  timer write enable
- wdata  out  XLEN  timer write data
- rdata  in  XLEN  timer read data, valid the cycle after sel

## Operation
- FSM states: IDLE, ISSUE, CAPT, DONE.
- IDLE:
  - Pick a requester and latch its addr/we/wdata/lock into payload registers.
  - Record the winner in `owner`, then go to ISSUE.
- ISSUE:
  - sel=1 with the latched payload for exactly one cycle, then go to CAPT.
- CAPT:
  - Register rdata into the owner's mN_rdata, then go to DONE.
  - Writes also capture (the value is don't-care).
- DONE:
  - Pulse owner's mN_ack, then go to IDLE.
- Arbitration in IDLE:
  - If a lock is held, only the lock owner may be granted.
  - Otherwise, with a single requester, grant that requester.
  - With both requesting, grant the master that was not granted last (`last` pointer). `last` updates on every grant.
- Lock:
  - Set when a transaction completes with latched lock=1. Cleared when the owner's transaction completes with lock=0.
  - While the lock is held and the owner's req is low in IDLE, a counter increments. At LOCK_TMO the lock clears and the counter resets.
  - The counter resets on any grant.
- The non-owner's req is ignored (no ack) until it is granted. Payload changes while not granted have no effect.
- We codes pass through unmodified. No address decode is done in this block.

## Timing
- Reset values:
  - state=IDLE, `last`=1 (master 0 wins the first tie), lock clear, counter 0.
  - sel, addr, we, wdata, both acks and both rdatas are all 0.
- Latency: req sampled high in IDLE at cycle T gives sel at T+1, capture at T+2, and ack at T+3. The FSM returns to IDLE at T+4.
- Throughput: one transaction per 4 cycles.
- Master protocol: drop req or present the next request the cycle after ack.
  - If req is still high in IDLE at T+4, it is treated as a new transaction.
- sel is never asserted for two consecutive cycles.
- addr, we and wdata are 0 whenever sel=0.
- Simultaneous req in IDLE with no lock: grant follows the `last` rule.
- Simultaneous lock expiry and a non-owner req: the counter reaching LOCK_TMO clears the lock in that cycle. The non-owner is granted in the next IDLE cycle.
- Reset asserted mid-transaction (any state): next cycle all state returns to reset values. No ack is issued for the aborted transaction.

## Structure
- Shared header timer_arb.vh holds the FSM state encodings (2-bit) and the LOCK_TMO default. XLEN comes from core_general.vh.
- One sub-module, arb_rr2: a combinational two-input round-robin pick with lock mask.
  - Inputs: req[1:0], last, lock_vld, lock_owner.
  - Output: grant_id and grant_vld.
- Payload registers, FSM and lock counter live in timer_bus_arb.

## Test plan
- Single read:
  - Stimulus: m0 reads addr 0x0000 with the timer returning 0x1234_5678.
  - Response: sel high at T+1 only, m0_ack at T+3, m0_rdata=0x1234_5678, m1_ack stays 0.
- Tie round-robin:
  - Stimulus: both masters request continuously from reset with addrs 0x10 and 0x20.
  - Response: grants alternate m0, m1, m0, m1. addr sequence on sel cycles is 0x10, 0x20, 0x10, 0x20. Each ack is 4 cycles apart.
- Locked 64-bit write:
  - Stimulus: m1 writes 0x4000 with lock=1, then 0x4004 with lock=0, while m0 requests throughout.
  - Response: both m1 transactions complete before any m0 sel. m0 is granted in the IDLE after the second m1 ack.
- Lock timeout:
  - Stimulus: m0 completes with lock=1 then drops req, while m1 requests.
  - Response: m1 is not granted for 16 IDLE cycles. The lock then clears and m1 sel appears exactly 2 cycles after expiry.
- Reset mid-transaction:
  - Stimulus: assert rst_n=0 in the CAPT cycle of an m1 read.
  - Response: no m1_ack, and all outputs are 0 the next cycle. After release with both requesting, m0 is granted first.
